// File: rtl/uart_seg7_display.sv
// uart_seg7_display: turns received UART bytes into a 4-digit scrolling
// 7-segment readout with multiplexed scan and per-slot anti-ghost blanking.
module uart_seg7_display #(
    parameter int unsigned SCAN_DIV     = 30000,
    parameter int unsigned BLANK_CYCLES = 300,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [2:0] digit_count,
    output logic       byte_err
);

    localparam int unsigned CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0]  CODE_DASH  = 4'd10;
    localparam logic [3:0]  CODE_BLANK = 4'hF;

    logic [3:0][3:0] digits, digits_n;
    logic [2:0]      count, count_n;
    logic            err, err_n;
    logic [CW-1:0]   scan_cnt, scan_cnt_n;
    logic [1:0]      scan_idx, scan_idx_n;
    logic [6:0]      seg_q, seg_n;
    logic [3:0]      an_q, an_n;
    logic            blanking;
    logic            slot_end;
    logic [3:0]      new_code;

    // Active-high gfedcba glyph for a buffer code; unknown codes show nothing.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            4'd10:   g = 7'h40;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    // Byte decode: scroll in, delete, clear, ignore line endings, flag the rest.
    always_comb begin
        digits_n = digits;
        count_n  = count;
        err_n    = 1'b0;
        new_code = (rx_data == 8'h2D) ? CODE_DASH : rx_data[3:0];
        if (rx_valid) begin
            if ((rx_data >= 8'h30 && rx_data <= 8'h39) || rx_data == 8'h2D) begin
                digits_n = {digits[2:0], new_code};
                count_n  = (count == 3'd4) ? 3'd4 : count + 3'd1;
            end else if (rx_data == 8'h08) begin
                if (count != 3'd0) begin
                    digits_n = {CODE_BLANK, digits[3:1]};
                    count_n  = count - 3'd1;
                end
            end else if (rx_data == 8'h43 || rx_data == 8'h63) begin
                digits_n = {4{CODE_BLANK}};
                count_n  = 3'd0;
            end else if (rx_data == 8'h0D || rx_data == 8'h0A) begin
                digits_n = digits;
            end else begin
                err_n = 1'b1;
            end
        end
    end

    // Scan timing and the next registered segment/anode pattern.
    always_comb begin
        slot_end   = (scan_cnt == CW'(SCAN_DIV - 1));
        scan_cnt_n = slot_end ? '0 : scan_cnt + CW'(1);
        scan_idx_n = slot_end ? scan_idx + 2'd1 : scan_idx;
        blanking   = (32'(scan_cnt) < BLANK_CYCLES);
        an_n       = 4'b0000;
        seg_n      = 7'h00;
        if (!blanking) begin
            an_n  = 4'b0001 << scan_idx;
            seg_n = glyph(digits[scan_idx]);
        end
    end

    // State and output registers; reset forces the display dark immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits   <= {4{CODE_BLANK}};
            count    <= 3'd0;
            err      <= 1'b0;
            scan_cnt <= '0;
            scan_idx <= 2'd0;
            seg_q    <= 7'h00;
            an_q     <= 4'b0000;
        end else begin
            digits   <= digits_n;
            count    <= count_n;
            err      <= err_n;
            scan_cnt <= scan_cnt_n;
            scan_idx <= scan_idx_n;
            seg_q    <= seg_n;
            an_q     <= an_n;
        end
    end

    // Pin polarity for common-anode boards.
    assign seg         = seg_q ^ {7{ACTIVE_LOW}};
    assign an          = an_q ^ {4{ACTIVE_LOW}};
    assign digit_count = count;
    assign byte_err    = err;

endmodule

// File: tb/tb_uart_seg7_display.sv
// Directed bench for uart_seg7_display with a short scan (8 clocks, 2 blank).
module tb_uart_seg7_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] digit_count;
    logic       byte_err;

    int checks   = 0;
    int failures = 0;

    uart_seg7_display #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .seg        (seg),
        .an         (an),
        .digit_count(digit_count),
        .byte_err   (byte_err)
    );

    always #5 clk = ~clk;

    // One-cycle strobe; returns at the negedge after the sampling edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait (bounded) until the given slot's anode is lit.
    task automatic wait_slot(input int idx, output bit found);
        logic [3:0] want;
        want  = 4'(~(4'b0001 << idx));
        found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if (an === want) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        checks++;
        if (an !== 4'hF) begin failures++; $display("FAIL reset_an got=%h exp=f", an); end
        checks++;
        if (digit_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
        checks++;
        if (byte_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", byte_err); end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        int c, i;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            c = (k - 1) % 8;
            i = ((k - 1) / 8) % 4;
            exp_an = (c < 2) ? 4'hF : 4'(~(4'b0001 << i));
            checks++;
            if (an !== exp_an) begin
                failures++;
                $display("FAIL scan_an k=%0d got=%h exp=%h", k, an, exp_an);
            end
            checks++;
            if (seg !== 7'h7F) begin
                failures++;
                $display("FAIL scan_seg k=%0d got=%h exp=7f", k, seg);
            end
        end
    endtask

    task automatic test_shift();
        logic [6:0] exp_seg [4];
        bit f;
        exp_seg = '{7'h6D, 7'h66, 7'h4F, 7'h5B};
        send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h35);
        checks++;
        if (digit_count !== 3'd4) begin failures++; $display("FAIL shift_count got=%0d exp=4", digit_count); end
        for (int i = 0; i < 4; i++) begin
            wait_slot(i, f);
            checks++;
            if (!f || ((~seg) & 7'h7F) !== exp_seg[i]) begin
                failures++;
                $display("FAIL shift_slot%0d got=%h exp=%h lit=%0d", i, (~seg) & 7'h7F, exp_seg[i], f);
            end
        end
    endtask

    task automatic test_backspace();
        bit f;
        send(8'h43);
        send(8'h37); send(8'h2D);
        checks++;
        if (digit_count !== 3'd2) begin failures++; $display("FAIL bs_pre_count got=%0d exp=2", digit_count); end
        wait_slot(0, f);
        checks++;
        if (!f || ((~seg) & 7'h7F) !== 7'h40) begin failures++; $display("FAIL bs_dash got=%h exp=40", (~seg) & 7'h7F); end
        send(8'h08);
        checks++;
        if (digit_count !== 3'd1) begin failures++; $display("FAIL bs1_count got=%0d exp=1", digit_count); end
        wait_slot(0, f);
        checks++;
        if (!f || ((~seg) & 7'h7F) !== 7'h07) begin failures++; $display("FAIL bs1_slot0 got=%h exp=07", (~seg) & 7'h7F); end
        wait_slot(1, f);
        checks++;
        if (!f || ((~seg) & 7'h7F) !== 7'h00) begin failures++; $display("FAIL bs1_slot1 got=%h exp=00", (~seg) & 7'h7F); end
        send(8'h08);
        checks++;
        if (digit_count !== 3'd0) begin failures++; $display("FAIL bs2_count got=%0d exp=0", digit_count); end
        send(8'h08);
        checks++;
        if (digit_count !== 3'd0) begin failures++; $display("FAIL bs3_count got=%0d exp=0", digit_count); end
        checks++;
        if (byte_err !== 1'b0) begin failures++; $display("FAIL bs3_err got=%b exp=0", byte_err); end
    endtask

    task automatic test_error();
        bit f;
        send(8'h36);
        send(8'h78);
        checks++;
        if (byte_err !== 1'b1) begin failures++; $display("FAIL err_high got=%b exp=1", byte_err); end
        @(negedge clk);
        checks++;
        if (byte_err !== 1'b0) begin failures++; $display("FAIL err_low got=%b exp=0", byte_err); end
        checks++;
        if (digit_count !== 3'd1) begin failures++; $display("FAIL err_count got=%0d exp=1", digit_count); end
        wait_slot(0, f);
        checks++;
        if (!f || ((~seg) & 7'h7F) !== 7'h7D) begin failures++; $display("FAIL err_slot0 got=%h exp=7d", (~seg) & 7'h7F); end
        send(8'h0D);
        checks++;
        if (byte_err !== 1'b0) begin failures++; $display("FAIL cr_err got=%b exp=0", byte_err); end
        send(8'h0A);
        checks++;
        if (byte_err !== 1'b0) begin failures++; $display("FAIL lf_err got=%b exp=0", byte_err); end
        checks++;
        if (digit_count !== 3'd1) begin failures++; $display("FAIL crlf_count got=%0d exp=1", digit_count); end
    endtask

    task automatic test_back_to_back();
        bit f;
        send(8'h63);
        @(negedge clk);
        rx_data = 8'h34; rx_valid = 1'b1;
        @(negedge clk);
        rx_data = 8'h32;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (digit_count !== 3'd2) begin failures++; $display("FAIL b2b_digits_count got=%0d exp=2", digit_count); end
        wait_slot(0, f);
        checks++;
        if (!f || ((~seg) & 7'h7F) !== 7'h5B) begin failures++; $display("FAIL b2b_slot0 got=%h exp=5b", (~seg) & 7'h7F); end
        wait_slot(1, f);
        checks++;
        if (!f || ((~seg) & 7'h7F) !== 7'h66) begin failures++; $display("FAIL b2b_slot1 got=%h exp=66", (~seg) & 7'h7F); end
        @(negedge clk);
        rx_data = 8'h39; rx_valid = 1'b1;
        @(negedge clk);
        rx_data = 8'h63;
        @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (digit_count !== 3'd0) begin failures++; $display("FAIL b2b_clear_count got=%0d exp=0", digit_count); end
        for (int i = 0; i < 4; i++) begin
            wait_slot(i, f);
            checks++;
            if (!f || ((~seg) & 7'h7F) !== 7'h00) begin
                failures++;
                $display("FAIL b2b_clear_slot%0d got=%h exp=00 lit=%0d", i, (~seg) & 7'h7F, f);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit f;
        send(8'h43);
        send(8'h31); send(8'h32); send(8'h33);
        wait_slot(2, f);
        checks++;
        if (!f || ((~seg) & 7'h7F) !== 7'h06) begin failures++; $display("FAIL mid_pre_slot2 got=%h exp=06", (~seg) & 7'h7F); end
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF) begin failures++; $display("FAIL mid_async_an got=%h exp=f", an); end
        checks++;
        if (seg !== 7'h7F) begin failures++; $display("FAIL mid_async_seg got=%h exp=7f", seg); end
        checks++;
        if (digit_count !== 3'd0) begin failures++; $display("FAIL mid_async_count got=%0d exp=0", digit_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (an !== ((k < 3) ? 4'hF : 4'hE)) begin
                failures++;
                $display("FAIL mid_restart_an k=%0d got=%h exp=%h", k, an, (k < 3) ? 4'hF : 4'hE);
            end
        end
        checks++;
        if (seg !== 7'h7F) begin failures++; $display("FAIL mid_restart_seg got=%h exp=7f", seg); end
        checks++;
        if (digit_count !== 3'd0) begin failures++; $display("FAIL mid_restart_count got=%0d exp=0", digit_count); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_shift();
        test_backspace();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule

// File: doc/uart_seg7_display.md
Name: uart_seg7_display

Overview:
- Consumes bytes from the UART receiver and drives a 4-digit multiplexed 7-segment display.
- ASCII digits scroll in from the right. Control characters clear the display or delete the rightmost digit.
- The block owns the digit buffer, the scan timing and the anti-ghosting blanking; the board connects its outputs directly to the segment and anode pins.

Parameters:
- SCAN_DIV, 30000: clocks per digit slot (1 kHz slot rate at 30 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 300: clocks at the start of each slot with all anodes off (anti-ghosting); 0 disables blanking.
- ACTIVE_LOW, 1: when 1, seg and an are inverted at the output (common-anode board).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  received byte; valid only while rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
- an  output  4  digit enables, an[0]=rightmost, polarity per ACTIVE_LOW
- digit_count  output  3  number of non-blank digits held (0..4)
- byte_err  output  1  one-cycle pulse when a byte is ignored

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values (logical): all 4 buffer slots blank; digit_count=0; byte_err=0; scan index=0; scan counter=0; an all off; seg all off. Physical pins are driven inverted when ACTIVE_LOW=1.
- Buffer: 4 slots d3..d0. Each slot is a 4-bit code: 0-9 = digit, 10 = dash, 15 = blank.
- Byte decode, evaluated only on cycles with rx_valid=1:
  - 0x30-0x39 or 0x2D ('-'): shift left (d3<=d2, d2<=d1, d1<=d0, d0<=new). The previous d3 is lost. digit_count = min(count+1, 4).
  - 0x08 (backspace): shift right (d0<=d1, d1<=d2, d2<=d3, d3<=blank). digit_count = max(count-1, 0). Backspace on an empty buffer does nothing and is not an error.
  - 0x43 'C' or 0x63 'c': all slots blank, digit_count=0.
  - 0x0D and 0x0A: ignored silently, no byte_err (terminal line endings).
  - Any other value: buffer unchanged; byte_err=1 on the next cycle for exactly one cycle.
- Timing: buffer and digit_count update on the clock edge that samples rx_valid=1. Back-to-back strobes on consecutive cycles are each processed.
- Scan:
  - scan counter runs 0..SCAN_DIV-1 and wraps. On wrap, scan index increments mod 4 (0->1->2->3->0).
  - While counter < BLANK_CYCLES: an all off, seg all off.
  - Otherwise: an is one-hot at the scan index, and seg is the glyph of slot d[index].
  - A blank slot drives seg off, but its anode is still enabled.
- Glyphs (active-high, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, blank=00.
- Output latency: seg and an are registered. A buffer change is visible on seg one cycle after the update edge, provided the slot is currently shown and not in blanking. The rx path never resets or perturbs the scan counter.
- Reset mid-operation: asynchronous clear of every register. Outputs go off immediately, without waiting for a clock edge.

Test Plan:
- Reset, SCAN_DIV=8, BLANK_CYCLES=2: seg=7F and an=F (ACTIVE_LOW=1) held. After release, an cycles E,D,B,7 per 8-clock slot, with 2 blank clocks (an=F) at the start of each slot.
- Send '1','2','3','4','5' -> buffer 2,3,4,5 (the 1 is dropped); digit_count=4. Slot 0 seg (active-high view) = 6D; slot 3 seg = 5B.
- Send '7','-', then backspace -> d0=7, d1..d3 blank, digit_count=1. A further backspace gives digit_count=0; a third backspace changes nothing and gives byte_err=0.
- Send 'x' (0x78) -> byte_err high for exactly one cycle, buffer unchanged. Send 0x0D -> no byte_err.
- Send '9' then 'c' on consecutive-cycle strobes -> buffer all blank, digit_count=0, and seg stays 00 for all slots.
- Assert reset mid-slot, with counter=5 and index=2 and buffer holding digits -> an and seg go off asynchronously. After release the scan restarts at index 0 and counter 0, with an empty buffer.
